// File: rtl/phase_sweep_gen_if.sv
// rtl/phase_sweep_gen_if.sv - pixel phase stream bundle between generator and sink
interface phase_sweep_gen_if #(
    parameter int XW = 1,
    parameter int YW = 1
);
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   phase;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          sof;
    logic          eol;
    logic          eof;

    modport master (
        output out_valid, phase, pix_x, pix_y, sof, eol, eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, phase, pix_x, pix_y, sof, eol, eof,
        output out_ready
    );
endinterface

// File: rtl/phase_sweep_gen.sv
// rtl/phase_sweep_gen.sv - raster-order 16-bit phase sweep with valid/ready output
// Optional per-frame base animation: PHASE_SWEEP_FRAME_ANIM_EN
module phase_sweep_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int GAP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [15:0]         x_step,
    input  logic [15:0]         y_step,
    input  logic [15:0]         frame_step,
    output logic                busy,
    phase_sweep_gen_if.master   ps
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

`ifdef PHASE_SWEEP_FRAME_ANIM_EN
    localparam logic [15:0] ANIM_MASK = 16'hFFFF;
`else
    // Masking frame_step to zero keeps frame_base constant and lets the
    // shadow register collapse to a constant.
    localparam logic [15:0] ANIM_MASK = 16'h0000;
`endif

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   pix_phase;
    logic [15:0]   line_phase;
    logic [15:0]   frame_base;
    logic [15:0]   xs;
    logic [15:0]   ys;
    logic [15:0]   fs;
    logic [GW-1:0] gap_cnt;
    logic          run;
    logic          xfer;
    logic          last_x;
    logic          last_y;

    assign run    = (state == RUN);
    assign xfer   = run && ps.out_ready;
    assign last_x = (x == X_LAST);
    assign last_y = (y == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (xfer && last_x && last_y) begin
                    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == G_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Phase is accumulated incrementally; line_phase tracks the start of the current row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            pix_phase  <= '0;
            line_phase <= '0;
            frame_base <= '0;
            xs         <= '0;
            ys         <= '0;
            fs         <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        xs         <= x_step;
                        ys         <= y_step;
                        fs         <= frame_step & ANIM_MASK;
                        x          <= '0;
                        y          <= '0;
                        pix_phase  <= frame_base;
                        line_phase <= frame_base;
                    end
                end
                RUN: begin
                    if (ps.out_ready) begin
                        if (!last_x) begin
                            x         <= x + 1'b1;
                            pix_phase <= pix_phase + xs;
                        end else if (!last_y) begin
                            x          <= '0;
                            y          <= y + 1'b1;
                            line_phase <= line_phase + ys;
                            pix_phase  <= line_phase + ys;
                        end else begin
                            frame_base <= frame_base + fs;
                            gap_cnt    <= '0;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ps.out_valid = run;
    assign ps.phase     = pix_phase;
    assign ps.pix_x     = x;
    assign ps.pix_y     = y;
    assign ps.sof       = run && (x == '0) && (y == '0);
    assign ps.eol       = run && last_x;
    assign ps.eof       = run && last_x && last_y;
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_phase_sweep_gen.sv
// tb/tb_phase_sweep_gen.sv - scoreboard bench for phase_sweep_gen (4x2 frame, 2 gap cycles)
module tb_phase_sweep_gen;
    localparam int H = 4;
    localparam int V = 2;
    localparam int G = 2;

    typedef struct packed {
        logic [15:0] ph;
        logic [1:0]  x;
        logic        y;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] x_step = '0;
    logic [15:0] y_step = '0;
    logic [15:0] frame_step = '0;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_base = '0;
    pix_t        q[$];

    phase_sweep_gen_if #(.XW(2), .YW(1)) ps_if ();

    phase_sweep_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .GAP_CYCLES(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x_step     (x_step),
        .y_step     (y_step),
        .frame_step (frame_step),
        .busy       (busy),
        .ps         (ps_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Closed-form expectation for one frame starting at the modelled base.
    task automatic push_frame(input logic [15:0] xs, input logic [15:0] ys, input logic [15:0] fs);
        pix_t e;
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                e.ph  = 16'(exp_base + 16'(xx) * xs + 16'(yy) * ys);
                e.x   = 2'(xx);
                e.y   = 1'(yy);
                e.sof = (xx == 0) && (yy == 0);
                e.eol = (xx == H - 1);
                e.eof = (xx == H - 1) && (yy == V - 1);
                q.push_back(e);
            end
        end
`ifdef PHASE_SWEEP_FRAME_ANIM_EN
        exp_base = exp_base + fs;
`else
        exp_base = exp_base + (fs & 16'h0000);
`endif
    endtask

    // Called at a negedge; observes, then advances one cycle at a time.
    task automatic drain(input int n, input int stall_at, input int drop_at);
        int   done = 0;
        int   cyc = 0;
        int   stall = 0;
        pix_t e;
        while (done < n && cyc < 200) begin
            if (ps_if.out_valid) begin
                e = (q.size() > 0) ? q[0] : '0;
                chk("phase", 32'(ps_if.phase), 32'(e.ph));
                chk("pix_x", 32'(ps_if.pix_x), 32'(e.x));
                chk("pix_y", 32'(ps_if.pix_y), 32'(e.y));
                chk("flags", 32'({ps_if.sof, ps_if.eol, ps_if.eof}), 32'({e.sof, e.eol, e.eof}));
                if (done == drop_at) begin
                    en = 1'b0;
                    x_step = 16'hFFFF;
                    y_step = 16'hFFFF;
                end
                if (done == stall_at && stall < 3) begin
                    ps_if.out_ready = 1'b0;
                    stall++;
                end else begin
                    ps_if.out_ready = 1'b1;
                    if (q.size() > 0) void'(q.pop_front());
                    done++;
                end
            end else begin
                ps_if.out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("drain_count", 32'(done), 32'(n));
    endtask

    initial begin
        int gap;
        ps_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ps_if.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_phase", 32'(ps_if.phase), 32'd0);
        chk("rst_flags", 32'({ps_if.sof, ps_if.eol, ps_if.eof}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame followed by an animated second frame; en drops in frame 2.
        x_step = 16'h0100; y_step = 16'h1000; frame_step = 16'h0040;
        en = 1'b1;
        push_frame(16'h0100, 16'h1000, 16'h0040);
        drain(8, -1, -1);
        gap = 0;
        while (!ps_if.out_valid && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        chk("frame_gap", 32'(gap), 32'd3);
        push_frame(16'h0100, 16'h1000, 16'h0040);
        drain(8, -1, 1);
        repeat (8) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(ps_if.out_valid), 32'd0);

        // Wrap-around with backpressure on pixel 2.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_base = '0;
        x_step = 16'hC000; y_step = 16'h0000; frame_step = 16'h0040;
        en = 1'b1;
        push_frame(16'hC000, 16'h0000, 16'h0040);
        drain(8, 2, 1);
        repeat (8) @(negedge clk);
        chk("idle_busy2", 32'(busy), 32'd0);

        // Reset at pixel 5, then a clean restart.
        x_step = 16'h0100; y_step = 16'h1000;
        en = 1'b1;
        push_frame(16'h0100, 16'h1000, 16'h0040);
        drain(5, -1, -1);
        chk("pre_rst_valid", 32'(ps_if.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ps_if.out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_phase", 32'(ps_if.phase), 32'd0);
        q.delete();
        exp_base = '0;
        @(negedge clk);
        rst = 1'b0;
        x_step = 16'h0100; y_step = 16'h1000;
        push_frame(16'h0100, 16'h1000, 16'h0040);
        drain(8, -1, 1);
        repeat (8) @(negedge clk);
        chk("final_busy", 32'(busy), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
